// File: rtl/spi_fsm.sv
// SPI slave transaction sequencer: address byte, then read or write data byte.
// Define SPI_FSM_DEBUG_EN to expose state_dbg / cnt_dbg observation ports.
module spi_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       sclk_rise,
  input  logic       sclk_fall,
  input  logic       rw_bit,
  output logic [1:0] sr_mode,
  output logic       addr_we,
  output logic       dm_we,
  output logic       miso_buff,
  output logic       busy
`ifdef SPI_FSM_DEBUG_EN
  ,
  output logic [2:0] state_dbg,
  output logic [3:0] cnt_dbg
`endif
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    GET_ADDR     = 3'd1,
    GOT_ADDR     = 3'd2,
    READ_LOAD    = 3'd3,
    READ_SHIFT   = 3'd4,
    WRITE_SHIFT  = 3'd5,
    WRITE_COMMIT = 3'd6,
    DONE         = 3'd7
  } state_e;

  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_SHIFT = 2'b10;
  localparam logic [1:0] SR_LOAD  = 2'b11;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_mode   = SR_HOLD;
    addr_we   = 1'b0;
    dm_we     = 1'b0;
    miso_buff = 1'b0;
    busy      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (!cs_n) begin
          state_d = GET_ADDR;
          cnt_d   = 4'd0;
        end
      end
      GET_ADDR: begin
        if (sclk_rise) begin
          sr_mode = SR_SHIFT;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) state_d = GOT_ADDR;
        end
      end
      GOT_ADDR: begin
        addr_we = 1'b1;
        cnt_d   = 4'd0;
        state_d = rw_bit ? READ_LOAD : WRITE_SHIFT;
      end
      READ_LOAD: begin
        sr_mode   = SR_LOAD;
        miso_buff = 1'b1;
        state_d   = READ_SHIFT;
      end
      READ_SHIFT: begin
        miso_buff = 1'b1;
        if (sclk_fall) begin
          sr_mode = SR_SHIFT;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) state_d = DONE;
        end
      end
      WRITE_SHIFT: begin
        if (sclk_rise) begin
          sr_mode = SR_SHIFT;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) state_d = WRITE_COMMIT;
        end
      end
      WRITE_COMMIT: begin
        dm_we   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = state_q;
      end
    endcase

    // Deselect aborts from anywhere; this cycle's outputs are left intact.
    if (state_q != IDLE && cs_n) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end
  end

`ifdef SPI_FSM_DEBUG_EN
  assign state_dbg = state_q;
  assign cnt_dbg   = cnt_q;
`endif

endmodule

// File: tb/tb_spi_fsm.sv
// Directed bench for spi_fsm: reset, read, write, abort and stray-strobe cases.
module tb_spi_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_n;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       rw_bit;
  logic [1:0] sr_mode;
  logic       addr_we;
  logic       dm_we;
  logic       miso_buff;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // {sr_mode, addr_we, dm_we, miso_buff, busy}
  localparam logic [5:0] E_IDLE  = 6'b00_0_0_0_0;
  localparam logic [5:0] E_BUSY  = 6'b00_0_0_0_1;
  localparam logic [5:0] E_SHIFT = 6'b10_0_0_0_1;
  localparam logic [5:0] E_AWE   = 6'b00_1_0_0_1;
  localparam logic [5:0] E_DWE   = 6'b00_0_1_0_1;
  localparam logic [5:0] E_LOAD  = 6'b11_0_0_1_1;
  localparam logic [5:0] E_RSH   = 6'b10_0_0_1_1;
  localparam logic [5:0] E_RHOLD = 6'b00_0_0_1_1;

  always #5 clk = ~clk;

  spi_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .cs_n      (cs_n),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .rw_bit    (rw_bit),
    .sr_mode   (sr_mode),
    .addr_we   (addr_we),
    .dm_we     (dm_we),
    .miso_buff (miso_buff),
    .busy      (busy)
  );

  // Entered at posedge+1: drive, check mid-cycle, advance to next posedge+1.
  task automatic step(input string tag, input logic cs, input logic r,
                      input logic f, input logic rw, input logic [5:0] exp);
    logic [5:0] obs;
    cs_n      = cs;
    sclk_rise = r;
    sclk_fall = f;
    rw_bit    = rw;
    #3;
    obs = {sr_mode, addr_we, dm_we, miso_buff, busy};
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  // Eight rises with gaps; returns at the cycle that should be GOT_ADDR.
  task automatic addr8(input string tag);
    for (int i = 0; i < 8; i++) begin
      step({tag, "_rise"}, 1'b0, 1'b1, 1'b0, 1'b0, E_SHIFT);
      if (i < 7) step({tag, "_gap"}, 1'b0, 1'b0, 1'b0, 1'b0, E_BUSY);
    end
  endtask

  initial begin
    reset = 1'b1; cs_n = 1'b1; sclk_rise = 1'b0;
    sclk_fall = 1'b0; rw_bit = 1'b0;
    @(posedge clk);
    #1;
    step("rst_hold", 1'b0, 1'b1, 1'b0, 1'b0, E_IDLE);
    reset = 1'b0;
    step("idle_cs1", 1'b1, 1'b1, 1'b1, 1'b0, E_IDLE);

    // Reset mid address phase, then a full read
    step("r_start", 1'b0, 1'b1, 1'b0, 1'b0, E_IDLE);
    for (int i = 0; i < 3; i++) begin
      step("pre_rise", 1'b0, 1'b1, 1'b0, 1'b0, E_SHIFT);
      step("pre_gap", 1'b0, 1'b0, 1'b0, 1'b0, E_BUSY);
    end
    reset = 1'b1;
    step("rst_mid", 1'b0, 1'b1, 1'b0, 1'b0, E_IDLE);
    reset = 1'b0;
    step("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
    step("r_start2", 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
    addr8("r_addr");
    step("r_got", 1'b0, 1'b0, 1'b0, 1'b1, E_AWE);
    step("r_load", 1'b0, 1'b0, 1'b0, 1'b0, E_LOAD);
    for (int i = 0; i < 8; i++) begin
      step("r_fall", 1'b0, 1'b0, 1'b1, 1'b0, E_RSH);
      if (i < 7) step("r_stray", 1'b0, 1'b1, 1'b0, 1'b0, E_RHOLD);
    end
    step("r_done", 1'b0, 1'b0, 1'b0, 1'b0, E_BUSY);
    step("r_end", 1'b1, 1'b0, 1'b0, 1'b0, E_BUSY);
    step("r_idle", 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);

    // Write with stray falls in the address phase
    step("w_start", 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
    step("w_fall0", 1'b0, 1'b0, 1'b1, 1'b0, E_BUSY);
    step("w_fall1", 1'b0, 1'b0, 1'b1, 1'b0, E_BUSY);
    addr8("w_addr");
    step("w_got", 1'b0, 1'b0, 1'b0, 1'b0, E_AWE);
    for (int i = 0; i < 8; i++) begin
      step("w_rise", 1'b0, 1'b1, 1'b0, 1'b0, E_SHIFT);
      if (i < 7) step("w_stray", 1'b0, 1'b0, 1'b1, 1'b0, E_BUSY);
    end
    step("w_commit", 1'b0, 1'b0, 1'b0, 1'b0, E_DWE);
    for (int i = 0; i < 4; i++)
      step("done_rise", 1'b0, 1'b1, 1'b0, 1'b0, E_BUSY);
    step("w_end", 1'b1, 1'b0, 1'b0, 1'b0, E_BUSY);
    step("w_idle", 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);

    // Abort after 5 data rises, then a commit cycle that sees deselect
    step("a_start", 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
    addr8("a_addr");
    step("a_got", 1'b0, 1'b0, 1'b0, 1'b0, E_AWE);
    for (int i = 0; i < 5; i++) begin
      step("a_rise", 1'b0, 1'b1, 1'b0, 1'b0, E_SHIFT);
      step("a_gap", 1'b0, 1'b0, 1'b0, 1'b0, E_BUSY);
    end
    step("a_abort", 1'b1, 1'b0, 1'b0, 1'b0, E_BUSY);
    step("a_idle", 1'b1, 1'b1, 1'b0, 1'b0, E_IDLE);
    step("c_start", 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
    addr8("c_addr");
    step("c_got", 1'b0, 1'b0, 1'b0, 1'b0, E_AWE);
    for (int i = 0; i < 8; i++)
      step("c_rise", 1'b0, 1'b1, 1'b0, 1'b0, E_SHIFT);
    step("c_commit_cs1", 1'b1, 1'b0, 1'b0, 1'b0, E_DWE);
    step("c_idle", 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
